// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the 7-segment scan driver.
// Segment vectors are {g,f,e,d,c,b,a}, active low.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_e;

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'h3F;

    localparam int unsigned BLANK_CNT_W = 8;

    // Entry n is the glyph for value n; 10..15 are not BCD and render as a dash.
    localparam logic [15:0][6:0] SEG_GLYPHS = {
        SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low 7-segment glyph decoder.
module bcd_to_seg7
    import seg_scan_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg_n
);

    assign o_seg_n = SEG_GLYPHS[i_bcd];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with inter-digit blanking.
// Optional build macro: LEADING_ZERO_BLANK_EN (suppress leading zero digits).
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | after reset, all outputs off, waiting for the first tick
//   BLANK | anodes off for BLANK_CYCLES cycles after each digit switch
//   SHOW  | anode idx driven low, segments from snapshot digit idx
module seg_scan_driver
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick_in,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic                    frame_done
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0]       LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLANK_CNT_W-1:0] BLANK_LOAD = BLANK_CNT_W'(BLANK_CYCLES - 1);

    scan_state_e                  r_state;
    scan_state_e                  w_state_nxt;
    logic [IDX_W-1:0]             r_idx;
    logic [IDX_W-1:0]             w_idx_nxt;
    logic [BLANK_CNT_W-1:0]       r_blank_cnt;
    logic [BLANK_CNT_W-1:0]       w_blank_cnt_nxt;
    logic [NUM_DIGITS-1:0][3:0]   r_snap_bcd;
    logic [NUM_DIGITS-1:0]        r_snap_dp;
    logic                         w_snap_load;
    logic                         w_frame_done_nxt;
    logic [NUM_DIGITS-1:0]        w_an_n_nxt;
    logic [6:0]                   w_seg_n_nxt;
    logic                         w_dp_n_nxt;
    logic [NUM_DIGITS-1:0]        w_lz_blank;
    logic [3:0]                   w_sel_bcd;
    logic                         w_sel_dp;
    logic [6:0]                   w_glyph;

    assign w_sel_bcd = r_snap_bcd[r_idx];
    assign w_sel_dp  = r_snap_dp[r_idx];

    bcd_to_seg7 u_bcd_to_seg7 (
        .i_bcd   (w_sel_bcd),
        .o_seg_n (w_glyph)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is suppressed while it and every digit above it are zero without dp.
    always_comb begin : lz_mask
        logic w_run_zero;
        w_run_zero = 1'b1;
        w_lz_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_run_zero    = w_run_zero & (r_snap_bcd[i] == 4'd0) & ~r_snap_dp[i];
            w_lz_blank[i] = w_run_zero;
        end
    end
`else
    assign w_lz_blank = '0;
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_idx_nxt        = r_idx;
        w_blank_cnt_nxt  = r_blank_cnt;
        w_snap_load      = 1'b0;
        w_frame_done_nxt = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (tick_in) begin
                    w_snap_load     = 1'b1;
                    w_idx_nxt       = '0;
                    w_blank_cnt_nxt = BLANK_LOAD;
                    w_state_nxt     = BLANK;
                end
            end
            BLANK: begin
                if (r_blank_cnt == '0) begin
                    w_state_nxt = SHOW;
                end else begin
                    w_blank_cnt_nxt = r_blank_cnt - BLANK_CNT_W'(1);
                end
            end
            SHOW: begin
                if (tick_in) begin
                    if (r_idx == LAST_IDX) begin
                        w_idx_nxt        = '0;
                        w_frame_done_nxt = 1'b1;
                        w_snap_load      = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                    w_blank_cnt_nxt = BLANK_LOAD;
                    w_state_nxt     = BLANK;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Entering or staying in SHOW never moves idx or the snapshot, so the
        // current selection already describes the next displayed digit.
        w_an_n_nxt  = '1;
        w_seg_n_nxt = SEG_OFF;
        w_dp_n_nxt  = 1'b1;
        if ((w_state_nxt == SHOW) && !w_lz_blank[r_idx]) begin
            w_an_n_nxt  = ~(NUM_DIGITS'(1) << r_idx);
            w_seg_n_nxt = w_glyph;
            w_dp_n_nxt  = ~w_sel_dp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_blank_cnt <= '0;
            r_snap_bcd  <= '0;
            r_snap_dp   <= '0;
            an_n        <= '1;
            seg_n       <= SEG_OFF;
            dp_n        <= 1'b1;
            frame_done  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_blank_cnt <= w_blank_cnt_nxt;
            if (w_snap_load) begin
                r_snap_bcd <= bcd_in;
                r_snap_dp  <= dp_in;
            end
            an_n        <= w_an_n_nxt;
            seg_n       <= w_seg_n_nxt;
            dp_n        <= w_dp_n_nxt;
            frame_done  <= w_frame_done_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver against a slot-level display model.
module tb_seg_scan_driver;

    localparam int ND = 4;
    localparam int BC = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick_in = 1'b0;
    logic [15:0]   bcd_in = '0;
    logic [3:0]    dp_in = '0;
    logic [3:0]    an_n;
    logic [6:0]    seg_n;
    logic          dp_n;
    logic          frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: what the display should show, tracked per tick slot.
    int m_digit[ND];
    bit m_dp[ND];
    int m_idx = 0;
    bit m_active = 1'b0;

    seg_scan_driver #(
        .NUM_DIGITS   (ND),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_in    (tick_in),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .an_n       (an_n),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] ref_glyph(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    function automatic void model_latch();
        for (int i = 0; i < ND; i++) begin
            m_digit[i] = int'(bcd_in[4*i +: 4]);
            m_dp[i]    = dp_in[i];
        end
    endfunction

    function automatic bit ref_blanked(input int k);
        bit blanked;
        blanked = (k != 0);
`ifdef LEADING_ZERO_BLANK_EN
        for (int j = k; j < ND; j++)
            if (m_digit[j] != 0 || m_dp[j]) blanked = 1'b0;
`else
        blanked = 1'b0;
`endif
        return blanked;
    endfunction

    task automatic randomize_inputs();
        bcd_in = 16'($urandom);
        if ($urandom_range(0, 1) == 1) bcd_in[15:8] = 8'h00;
        dp_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick_in = 1'b0;
        step();
        step();
        rst = 1'b0;
        m_active = 1'b0;
        m_idx = 0;
    endtask

    // One scan slot: tick, BC blank cycles, then the digit held for hold+1 cycles.
    task automatic do_tick(input int hold, input int inject_at, input bit change_mid);
        bit         exp_fd;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        exp_fd = 1'b0;
        if (!m_active) begin
            model_latch();
            m_idx = 0;
            m_active = 1'b1;
        end else if (m_idx == ND - 1) begin
            model_latch();
            m_idx = 0;
            exp_fd = 1'b1;
        end else begin
            m_idx++;
        end
        tick_in = 1'b1;
        step();
        tick_in = 1'b0;
        for (int c = 1; c <= BC; c++) begin
            n_tests++;
            if ({an_n, seg_n, dp_n} !== {4'hF, 7'h7F, 1'b1}) begin
                n_fail++;
                $display("FAIL blank_c%0d an/seg/dp got %b/%h/%b want 1111/7f/1", c, an_n, seg_n, dp_n);
            end
            n_tests++;
            if (frame_done !== ((c == 1) ? exp_fd : 1'b0)) begin
                n_fail++;
                $display("FAIL frame_done_c%0d got %b want %b", c, frame_done, (c == 1) ? exp_fd : 1'b0);
            end
            if (c == inject_at) tick_in = 1'b1;
            step();
            tick_in = 1'b0;
        end
        if (ref_blanked(m_idx)) begin
            e_an = 4'hF;
            e_seg = 7'h7F;
            e_dp = 1'b1;
        end else begin
            e_an = ~(4'b0001 << m_idx);
            e_seg = ref_glyph(m_digit[m_idx]);
            e_dp = ~m_dp[m_idx];
        end
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) step();
            n_tests++;
            if ({an_n, seg_n, dp_n} !== {e_an, e_seg, e_dp}) begin
                n_fail++;
                $display("FAIL show_idx%0d_h%0d an/seg/dp got %b/%h/%b want %b/%h/%b",
                         m_idx, h, an_n, seg_n, dp_n, e_an, e_seg, e_dp);
            end
            n_tests++;
            if (frame_done !== 1'b0) begin
                n_fail++;
                $display("FAIL frame_done_show_h%0d got %b want 0", h, frame_done);
            end
            if (change_mid && h == hold / 2) randomize_inputs();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            n_tests++;
            if ({an_n, seg_n, dp_n, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_idle_%0d an/seg/dp/fd got %b/%h/%b/%b want 1111/7f/1/0",
                         i, an_n, seg_n, dp_n, frame_done);
            end
            step();
        end
    endtask

    task automatic test_scan_1234();
        do_reset();
        bcd_in = 16'h1234;
        dp_in = 4'h0;
        for (int t = 0; t < 5; t++) do_tick(15, 0, 1'b0);
    endtask

    task automatic test_snapshot();
        logic [6:0] want[4];
        want[0] = 7'h24;
        want[1] = 7'h79;
        want[2] = 7'h00;
        want[3] = 7'h78;
        do_reset();
        bcd_in = 16'h1234;
        dp_in = 4'h0;
        do_tick(6, 0, 1'b0);
        do_tick(6, 0, 1'b0);
        bcd_in = 16'h5678;
        for (int t = 0; t < 4; t++) begin
            do_tick(6, 0, 1'b0);
            n_tests++;
            if (seg_n !== want[t]) begin
                n_fail++;
                $display("FAIL snapshot_slot%0d seg got %h want %h", t, seg_n, want[t]);
            end
        end
    endtask

    task automatic test_dash_lz();
        do_reset();
        bcd_in = 16'h00A5;
        dp_in = 4'h0;
        do_tick(5, 0, 1'b0);
        do_tick(5, 0, 1'b0);
        n_tests++;
        if (seg_n !== 7'h3F) begin
            n_fail++;
            $display("FAIL dash_digit1 seg got %h want 3f", seg_n);
        end
        do_tick(5, 0, 1'b0);
        do_tick(5, 0, 1'b0);
        dp_in = 4'b0100;
        do_tick(5, 0, 1'b0);
        for (int t = 0; t < 4; t++) do_tick(3, 0, 1'b0);
    endtask

    task automatic test_blank_tick();
        do_reset();
        randomize_inputs();
        for (int t = 0; t < 10; t++) do_tick($urandom_range(1, 8), $urandom_range(1, BC), 1'b0);
    endtask

    task automatic test_rst_tick();
        do_reset();
        bcd_in = 16'h9876;
        dp_in = 4'b0010;
        for (int t = 0; t < ND; t++) do_tick(4, 0, 1'b0);
        rst = 1'b1;
        tick_in = 1'b1;
        step();
        rst = 1'b0;
        tick_in = 1'b0;
        m_active = 1'b0;
        m_idx = 0;
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if ({an_n, seg_n, dp_n, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL rst_tick_%0d an/seg/dp/fd got %b/%h/%b/%b want 1111/7f/1/0",
                         i, an_n, seg_n, dp_n, frame_done);
            end
            step();
        end
        do_tick(4, 0, 1'b0);
        do_tick(4, 0, 1'b0);
    endtask

    task automatic test_random();
        do_reset();
        randomize_inputs();
        for (int t = 0; t < 40; t++)
            do_tick($urandom_range(0, 12),
                    ($urandom_range(0, 2) == 0) ? $urandom_range(1, BC) : 0,
                    $urandom_range(0, 1) == 1);
    endtask

    initial begin
        test_reset();
        test_scan_1234();
        test_snapshot();
        test_dash_lz();
        test_blank_tick();
        test_rst_tick();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Consumer of the periodic one-cycle tick strobe: time-multiplexes a NUM_DIGITS BCD value onto a common-anode 7-segment display, one digit per tick. It sits between the binary-to-BCD converter (the digit source) and the board display pins. It inserts a blanking dead-time between digits to prevent ghosting, and latches a consistent snapshot of the digits once per frame.

## Interface
- NUM_DIGITS, 4: digits scanned per frame, 2..8.
- BLANK_CYCLES, 16: clk cycles all anodes are held off after each digit switch, 1..255.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tick_in  in  1  one-cycle scan strobe from the tick generator.
- bcd_in  in  4*NUM_DIGITS  BCD digits; digit 0 is [3:0] and least significant.
- dp_in  in  NUM_DIGITS  decimal-point request per digit.
- an_n  out  NUM_DIGITS  anode enables, active low, one-hot-low or all-high.
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active low.
- dp_n  out  1  decimal point, active low.
- frame_done  out  1  one-cycle pulse when the digit index wraps to 0.

## Operation
- FSM states: IDLE, BLANK, SHOW.
- IDLE: entered on reset. All outputs are off. On tick_in: latch the snapshot (bcd_in, dp_in), set idx=0, load the blank counter, go to BLANK.
- BLANK: an_n all ones; seg_n/dp_n all ones. The counter decrements each cycle. When it reaches 0, go to SHOW. tick_in is ignored in BLANK (integration requires BLANK_CYCLES < tick period).
- SHOW: an_n[idx]=0, other bits 1. seg_n/dp_n driven from the snapshot digit idx.
- On tick_in in SHOW: if idx==NUM_DIGITS-1, set idx=0, pulse frame_done, and re-latch the snapshot. Otherwise idx=idx+1. In both cases go to BLANK.
- Snapshot changes only at frame wrap or at the IDLE exit, so bcd_in changes mid-frame never tear a frame.
- Decode: 0-9 use the standard glyphs. 10-15 are invalid BCD and show "-" (seg_n=7'b0111111).
- idx width is clog2(NUM_DIGITS). idx must never exceed NUM_DIGITS-1.
- rst has priority over all events, including a simultaneous tick_in. A reset mid-digit returns to IDLE and turns off all anodes on the next edge.

## Timing
- All outputs are registered. Reset values: an_n all ones, seg_n 7'h7F, dp_n 1, frame_done 0, idx 0, state IDLE.
- tick_in sampled high at edge T in SHOW:
  - From edge T+1: anodes are off.
  - Edge T+1+BLANK_CYCLES: new digit anode low, with its segments valid in the same cycle.
- frame_done is high for exactly the cycle after the wrapping tick's edge (T+1).
- Anodes and segments change on the same edge. Segments never change while any anode is active.

## Configuration
- LEADING_ZERO_BLANK_EN defined: scanning from the most significant digit down, zero digits are blanked (anode kept high during their SHOW slot) until the first nonzero digit, or the first digit with dp set. Digit 0 is never blanked. Slot timing is unchanged.
- Undefined: every digit is displayed, including leading zeros.

## Structure
- Package seg_scan_pkg: state enum (IDLE/BLANK/SHOW), the 16-entry glyph constant table, and the SEG_OFF/SEG_DASH constants.
- Sub-module bcd_to_seg7: combinational 4-bit BCD to active-low 7-segment decoder, instantiated once on the selected snapshot digit.

## Test plan
- Reset then no tick for 100 cycles -> an_n=4'hF, seg_n=7'h7F, dp_n=1, frame_done=0 throughout.
- NUM_DIGITS=4, BLANK_CYCLES=4, bcd_in=16'h1234, tick every 20 cycles, over 4 ticks after the first:
  - an_n cycles 1110,1101,1011,0111.
  - seg_n reads 4, 3, 2, 1 glyphs (7'h19, 7'h30, 7'h24, 7'h79).
  - Anodes are off for exactly 4 cycles after each tick.
  - frame_done pulses once per 4 ticks.
- Change bcd_in 16'h1234→16'h5678 mid-frame -> remaining digits of the current frame still show 1234. Digits switch to 5678 only after frame_done.
- bcd_in=16'h00A5 -> digit 1 shows dash (7'h3F). With LEADING_ZERO_BLANK_EN, digits 3 and 2 are blanked (anode high). Without the macro, they show 0 (7'h40).
- tick_in during BLANK, and rst asserted together with tick_in in SHOW -> the BLANK tick is ignored (idx unchanged). The rst case gives IDLE with all outputs off on the next cycle.
